// File: rtl/armleocpu_regfile_mp_if.sv
// Register-file access bundle: decode-side read requests, writeback-side write port, clear status.
interface armleocpu_regfile_mp_if #(
   parameter int ELEMENTS_W = 5,
   parameter int WIDTH      = 32,
   parameter int NREAD      = 2
);
   logic                        busy;
   logic [NREAD-1:0]            rs_read;
   logic [NREAD*ELEMENTS_W-1:0] rs_addr;
   logic [NREAD*WIDTH-1:0]      rs_rdata;
   logic                        rd_write;
   logic [ELEMENTS_W-1:0]       rd_addr;
   logic [WIDTH-1:0]            rd_wdata;

   modport master (
      input  busy, rs_rdata,
      output rs_read, rs_addr, rd_write, rd_addr, rd_wdata
   );

   modport slave (
      output busy, rs_rdata,
      input  rs_read, rs_addr, rd_write, rd_addr, rd_wdata
   );
endinterface

// File: rtl/armleocpu_regfile_mp.sv
// Multi-read-port integer register file with a post-reset sequential clear engine.
// Optional macro ARMLEOCPU_REGFILE_BYPASS_EN: same-cycle write data is forwarded to colliding reads.
module armleocpu_regfile_mp #(
   parameter int ELEMENTS_W = 5,
   parameter int WIDTH      = 32,
   parameter int NREAD      = 2,
   parameter int ZERO_REG   = 1
) (
   input logic                    clk,
   input logic                    rst,
   armleocpu_regfile_mp_if.slave  bus
);
   localparam int ELEMENTS = 2 ** ELEMENTS_W;

   typedef enum logic {
      ST_CLEAR,
      ST_READY
   } state_t;

   state_t                             state, state_nxt;
   logic [ELEMENTS_W-1:0]              clear_ptr, clear_ptr_nxt;
   logic                               clear_we;
   logic                               wr_en;
   logic [NREAD-1:0][ELEMENTS_W-1:0]   port_addr;
   logic [NREAD-1:0][WIDTH-1:0]        rdata;

   // No reset on the array so it maps onto RAM; the clear engine zeroes it instead.
   logic [WIDTH-1:0] storage [ELEMENTS];

   assign port_addr    = bus.rs_addr;
   assign bus.rs_rdata = rdata;
   assign bus.busy     = (state == ST_CLEAR);

   assign wr_en = (state == ST_READY) && bus.rd_write &&
                  !((ZERO_REG != 0) && (bus.rd_addr == '0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_CLEAR;
         clear_ptr <= '0;
      end else begin
         state     <= state_nxt;
         clear_ptr <= clear_ptr_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      clear_ptr_nxt = clear_ptr;
      clear_we      = 1'b0;
      case (state)
         ST_CLEAR: begin
            clear_we      = 1'b1;
            clear_ptr_nxt = clear_ptr + 1'b1;
            if (&clear_ptr)
               state_nxt = ST_READY;
         end
         default: ;
      endcase
   end

   // Clearing is gated by rst so the array sees no writes while reset is held.
   always_ff @(posedge clk) begin
      if (clear_we && !rst)
         storage[clear_ptr] <= '0;
      else if (wr_en)
         storage[bus.rd_addr] <= bus.rd_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else begin
         for (int i = 0; i < NREAD; i++) begin
            if (bus.rs_read[i]) begin
               if (state == ST_CLEAR)
                  rdata[i] <= '0;
               else if ((ZERO_REG != 0) && (port_addr[i] == '0))
                  rdata[i] <= '0;
`ifdef ARMLEOCPU_REGFILE_BYPASS_EN
               else if (wr_en && (bus.rd_addr == port_addr[i]))
                  rdata[i] <= bus.rd_wdata;
`endif
               else
                  rdata[i] <= storage[port_addr[i]];
            end
         end
      end
   end
endmodule
